// File: rtl/sram_bist.sv
// sram_bist: two-pass fill-and-verify test engine driving a 1R/1W synchronous
// SRAM controller front-end.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   start_i              start a test; only honoured in IDLE or DONE
//   busy_o, done_o       test running / test finished (held until next start)
//   pass_o               valid with done_o: no data mismatch and no protocol error
//   err_count_o          saturating count of read data mismatches
//   first_err_valid_o    at least one mismatch seen
//   first_err_addr_o     address of the first mismatch
//   proto_err_o          sticky: an expected read response did not arrive
//   read_o/addr_o/wdata_o  request to the controller (read_o=0 means write)
//   read_valid_i/rdata_i   read response, LATENCY cycles after the request
module sram_bist #(
  parameter int unsigned        ADDR_W  = 14,
  parameter int unsigned        DATA_W  = 8,
  parameter logic [DATA_W-1:0]  SEED    = 8'hA5,
  parameter int unsigned        LATENCY = 2,
  parameter int unsigned        CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic              first_err_valid_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              proto_err_o,
  output logic              read_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              read_valid_i,
  input  logic [DATA_W-1:0] rdata_i
);

  localparam int unsigned EXT_W = ADDR_W + DATA_W;
  localparam int unsigned DRN_W = $clog2(LATENCY + 1);
  localparam int unsigned LAST  = LATENCY - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_R0, S_TURN, S_W1, S_R1, S_DRAIN, S_DONE
  } state_e;

  // P(a) = a[DATA_W-1:0] ^ (a >> DATA_W) ^ SEED, truncated to DATA_W
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [EXT_W-1:0] ax;
    ax = EXT_W'(a);
    return DATA_W'(ax) ^ DATA_W'(ax >> DATA_W) ^ SEED;
  endfunction

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_inc;
  logic [DATA_W-1:0]   wdata_q;
  logic                read_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [DRN_W-1:0]    drain_q;

  logic [CNT_W-1:0]    err_cnt_q,    err_cnt_d;
  logic                first_vld_q,  first_vld_d;
  logic [ADDR_W-1:0]   first_addr_q, first_addr_d;
  logic                proto_q,      proto_d;

  // Check pipe: index LAST is the stage whose response is due this cycle
  logic [LATENCY-1:0]             chk_q;
  logic [LATENCY-1:0][ADDR_W-1:0] paddr_q;
  logic [LATENCY-1:0][DATA_W-1:0] pexp_q;

  assign addr_inc = addr_q + 1'b1;

  // The request registers hold what is on the bus this cycle, so the pipe
  // captures them at the edge that ends the request cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_q   <= '0;
      paddr_q <= '0;
      pexp_q  <= '0;
    end else begin
      for (int unsigned i = LAST; i > 0; i--) begin
        chk_q[i]   <= chk_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
        pexp_q[i]  <= pexp_q[i-1];
      end
      chk_q[0]   <= (state_q == S_R0) || (state_q == S_R1);
      paddr_q[0] <= addr_q;
      pexp_q[0]  <= (state_q == S_R1) ? ~pat(addr_q) : pat(addr_q);
    end
  end

  always_comb begin
    err_cnt_d    = err_cnt_q;
    first_vld_d  = first_vld_q;
    first_addr_d = first_addr_q;
    proto_d      = proto_q;
    if (chk_q[LAST]) begin
      if (!read_valid_i) begin
        proto_d = 1'b1;
      end else if (rdata_i != pexp_q[LAST]) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (!first_vld_q) begin
          first_vld_d  = 1'b1;
          first_addr_d = paddr_q[LAST];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      drain_q      <= '0;
      err_cnt_q    <= '0;
      first_vld_q  <= 1'b0;
      first_addr_q <= '0;
      proto_q      <= 1'b0;
    end else begin
      err_cnt_q    <= err_cnt_d;
      first_vld_q  <= first_vld_d;
      first_addr_q <= first_addr_d;
      proto_q      <= proto_d;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q      <= S_W0;
            addr_q       <= '0;
            read_q       <= 1'b0;
            wdata_q      <= pat('0);
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            first_vld_q  <= 1'b0;
            first_addr_q <= '0;
            proto_q      <= 1'b0;
          end
        end
        S_W0, S_W1: begin
          if (addr_q == '1) begin
            state_q <= (state_q == S_W0) ? S_R0 : S_R1;
            addr_q  <= '0;
            read_q  <= 1'b1;
            wdata_q <= '0;
          end else begin
            addr_q  <= addr_inc;
            wdata_q <= (state_q == S_W0) ? pat(addr_inc) : ~pat(addr_inc);
          end
        end
        S_R0, S_R1: begin
          if (addr_q == '1) begin
            state_q <= (state_q == S_R0) ? S_TURN : S_DRAIN;
            addr_q  <= '0;
            drain_q <= '0;
          end else begin
            addr_q <= addr_inc;
          end
        end
        S_TURN: begin
          state_q <= S_W1;
          read_q  <= 1'b0;
          wdata_q <= ~pat('0);
        end
        S_DRAIN: begin
          if (drain_q == DRN_W'(LAST)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Final response is checked on this same edge, so use next values
            pass_q  <= (err_cnt_d == '0) && !proto_d;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_count_o       = err_cnt_q;
  assign first_err_valid_o = first_vld_q;
  assign first_err_addr_o  = first_addr_q;
  assign proto_err_o       = proto_q;
  assign read_o            = read_q;
  assign addr_o            = addr_q;
  assign wdata_o           = wdata_q;

endmodule

// File: tb/tb_sram_bist.sv
// tb_sram_bist: directed bench for sram_bist with ADDR_W=4 and a small
// latency-2 memory model that can inject data, stuck-bit and missing-response
// faults.
module tb_sram_bist;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy, done, pass, fev, proto, read_o;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_addr, addr_o;
  logic [DW-1:0] wdata_o;
  logic          rvalid;
  logic [DW-1:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  sram_bist #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .SEED   (8'hA5),
    .LATENCY(2),
    .CNT_W  (CW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_count),
    .first_err_valid_o(fev),
    .first_err_addr_o (first_addr),
    .proto_err_o      (proto),
    .read_o           (read_o),
    .addr_o           (addr_o),
    .wdata_o          (wdata_o),
    .read_valid_i     (rvalid),
    .rdata_i          (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model. mode: 0 ideal, 1 flip bit0 of addr 5 in pass 0,
  // 2 bit7 stuck at 0, 3 drop read_valid for addr 3 in pass 1.
  logic [DW-1:0] mem [16];
  logic          q1_v, q2_v, q1_p, q2_p;
  logic [AW-1:0] q1_a, q2_a;
  int            mode    = 0;
  int            wr_seen = 0;
  int            wr_base = 0;

  always @(posedge clk) begin
    if (!read_o) begin
      mem[addr_o] <= (mode == 2) ? (wdata_o & 8'h7F) : wdata_o;
      wr_seen     <= wr_seen + 1;
    end
    q1_v <= read_o;
    q1_a <= addr_o;
    q1_p <= (wr_seen - wr_base) > 16;
    q2_v <= q1_v;
    q2_a <= q1_a;
    q2_p <= q1_p;
  end

  always_comb begin
    rvalid = q2_v;
    rdata  = mem[q2_a];
    if (mode == 1 && q2_a == 4'd5 && !q2_p) rdata = rdata ^ 8'h01;
    if (mode == 3 && q2_a == 4'd3 && q2_p)  rvalid = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] p_of(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
    return v;
  endfunction

  // Expected {read, addr, wdata} in cycle c after the start edge
  function automatic logic [12:0] exp_req(input int c);
    if (c < 16)      return {1'b0, 4'(c), p_of(c)};
    else if (c < 32) return {1'b1, 4'(c - 16), 8'h00};
    else if (c < 33) return {1'b1, 4'd0, 8'h00};
    else if (c < 49) return {1'b0, 4'(c - 33), ~p_of(c - 33)};
    else if (c < 65) return {1'b1, 4'(c - 49), 8'h00};
    else             return {1'b1, 4'd0, 8'h00};
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_read"},   32'(read_o),     32'd1);
    check({pfx, "_addr"},   32'(addr_o),     32'd0);
    check({pfx, "_wdata"},  32'(wdata_o),    32'd0);
    check({pfx, "_busy"},   32'(busy),       32'd0);
    check({pfx, "_done"},   32'(done),       32'd0);
    check({pfx, "_pass"},   32'(pass),       32'd0);
    check({pfx, "_errcnt"}, 32'(err_count),  32'd0);
    check({pfx, "_fev"},    32'(fev),        32'd0);
    check({pfx, "_faddr"},  32'(first_addr), 32'd0);
    check({pfx, "_proto"},  32'(proto),      32'd0);
  endtask

  // Pulse (or hold) start, compare the request bus each cycle, return the
  // cycle index at which done_o is first seen (-1 if never).
  task automatic run_test(input int m, input bit hold, output int lat, output int seq_err);
    logic [12:0] e;
    mode = m;
    @(negedge clk);
    wr_base = wr_seen;
    start   = 1'b1;
    lat     = -1;
    seq_err = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      e = exp_req(c);
      if ({read_o, addr_o, wdata_o} !== e) seq_err++;
      if (!hold) start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  int lat, se;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal memory
    run_test(0, 1'b0, lat, se);
    check("ideal_latency", lat, 67);
    check("ideal_seq",     se, 0);
    check("ideal_pass",    32'(pass), 1);
    check("ideal_errcnt",  32'(err_count), 0);
    check("ideal_fev",     32'(fev), 0);
    check("ideal_proto",   32'(proto), 0);
    check("ideal_busy",    32'(busy), 0);

    // Single flipped bit at addr 5, pass 0
    run_test(1, 1'b0, lat, se);
    check("flip_latency", lat, 67);
    check("flip_errcnt",  32'(err_count), 1);
    check("flip_faddr",   32'(first_addr), 5);
    check("flip_fev",     32'(fev), 1);
    check("flip_pass",    32'(pass), 0);
    check("flip_proto",   32'(proto), 0);

    // Bit7 stuck at 0: P has bit7 set for all 16 addresses, ~P for none
    run_test(2, 1'b0, lat, se);
    check("stuck_errcnt", 32'(err_count), 16);
    check("stuck_faddr",  32'(first_addr), 0);
    check("stuck_fev",    32'(fev), 1);
    check("stuck_pass",   32'(pass), 0);

    // Missing response once in R1
    run_test(3, 1'b0, lat, se);
    check("drop_proto",  32'(proto), 1);
    check("drop_errcnt", 32'(err_count), 0);
    check("drop_pass",   32'(pass), 0);
    repeat (5) @(posedge clk);
    #1;
    check("drop_proto_sticky", 32'(proto), 1);
    check("drop_done_held",    32'(done), 1);

    // Async reset in W1 at addr 7, with errors already counted
    mode = 2;
    @(negedge clk);
    wr_base = wr_seen;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_addr",   32'(addr_o), 7);
    check("mid_read",   32'(read_o), 0);
    check("mid_errcnt", 32'(err_count), 16);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    run_test(0, 1'b0, lat, se);
    check("rerun_latency", lat, 67);
    check("rerun_seq",     se, 0);
    check("rerun_pass",    32'(pass), 1);

    // start held high through the run, then still high in DONE
    run_test(0, 1'b1, lat, se);
    check("hold_latency", lat, 67);
    check("hold_seq",     se, 0);
    check("hold_pass",    32'(pass), 1);
    @(posedge clk); #1;
    check("restart_done",  32'(done), 0);
    check("restart_busy",  32'(busy), 1);
    check("restart_read",  32'(read_o), 0);
    check("restart_addr",  32'(addr_o), 0);
    check("restart_wdata", 32'(wdata_o), 32'hA5);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c < 200; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    check("restart_latency", lat, 67);
    check("restart_pass",    32'(pass), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sram_bist.md
Name: sram_bist

Overview:
- Initiator/test engine for the 1R/1W synchronous SRAM controller front-end (request: read/addr/wdata; response: read_valid/rdata).
- Runs a two-pass fill-and-verify test over the full address space: write pattern, read back and compare, then repeat with inverted pattern.
- Reports pass/fail, a saturating error count, the first failing address, and a sticky protocol error.
- Sits between the board-level test/status logic and the SRAM controller.

Parameters:
- ADDR_W, 14, address width; depth = 2^ADDR_W.
- DATA_W, 8, data width.
- SEED, 8'hA5, pattern seed, DATA_W bits.
- LATENCY, 2, cycles from read request to read_valid_i/rdata_i.
- CNT_W, 16, error counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start test; sampled only in IDLE or DONE.
- busy_o  out  1  test running.
- done_o  out  1  test finished; held until next start.
- pass_o  out  1  valid when done_o; 1 iff err_count_o==0 and !proto_err_o.
- err_count_o  out  CNT_W  data mismatches, saturating.
- first_err_valid_o  out  1  at least one mismatch seen.
- first_err_addr_o  out  ADDR_W  address of first mismatch.
- proto_err_o  out  1  sticky: expected response missing.
- read_o  out  1  1=read request, 0=write request, every cycle.
- addr_o  out  ADDR_W  request address.
- wdata_o  out  DATA_W  write data.
- read_valid_i  in  1  read response strobe.
- rdata_i  in  DATA_W  read response data.

Behaviour:
- The controller writes on every cycle with read_o=0; there is no idle encoding. Whenever not in a write state (reset, IDLE, TURN, DRAIN, DONE), drive read_o=1, addr_o=0, wdata_o=0. Discard those reads.
- Reset values: read_o=1, addr_o=0, wdata_o=0, busy_o=0, done_o=0, pass_o=0, err_count_o=0, first_err_valid_o=0, first_err_addr_o=0, proto_err_o=0. State=IDLE, check pipe cleared.
- Pattern: P(a) = a[DATA_W-1:0] ^ (a >> DATA_W) ^ SEED, truncated to DATA_W. Pass 1 uses ~P(a).
- State sequence: IDLE -> W0 -> R0 -> TURN -> W1 -> R1 -> DRAIN -> DONE.
- start_i=1 in IDLE/DONE at an edge: go to W0, clear counters, error flags, done_o and pass_o; busy_o=1.
- start_i is ignored while busy.
- W0/W1: one write per cycle; addr_o = 0..2^ADDR_W-1 ascending; wdata_o = P/~P(addr_o); read_o=0.
- R0/R1: one read per cycle over the same addresses; read_o=1.
- Address counter wraps to 0 at end of each phase, and the state advances on that cycle.
- TURN: one discarded read cycle for bus turnaround before W1.
- DRAIN: LATENCY cycles; then DONE with busy_o=0, done_o=1 and pass_o computed.
- Check pipe: a LATENCY-deep shift register of {chk, addr, expected}.
  - chk=1 only for R0/R1 issues.
  - At stage LATENCY with chk=1:
    - read_valid_i=0: set proto_err_o.
    - read_valid_i=1 and rdata_i != expected: err_count_o++ (saturate at all-ones).
    - On the first mismatch: latch first_err_addr_o from the pipe address, set first_err_valid_o.
  - Ignore read_valid_i when chk=0.
- Cycle count: depth 2^N gives done_o high 4*2^N+1+LATENCY cycles after the start edge.
- Async reset mid-test: immediately return to reset values; read_o=1 so no spurious write.

Test Plan:
- ADDR_W=4, ideal memory model, start pulse:
  - Observe 16 writes of P(a) (a=0 -> 8'hA5, a=1 -> 8'hA4), then 16 reads, 1 turn cycle, 16 writes of ~P, 16 reads.
  - done_o rises 67 cycles after start; pass_o=1, err_count_o=0.
- Model flips bit0 of rdata for addr 5 in pass 0 only: err_count_o=1, first_err_addr_o=5, first_err_valid_o=1, pass_o=0.
- Model stuck bit7=0 at all addresses: pass 0 errors where P bit7=1; count equals the number of set bit7 in P over both passes. first_err_addr_o = lowest such address in pass 0.
- Model drops read_valid_i once in R1: proto_err_o=1 and stays set; pass_o=0.
- rst_ni low mid-W1 (addr 7): all outputs return to reset values within the same cycle, read_o=1. A new start reruns cleanly to pass_o=1.
- start_i held high during the run: no restart; a start in DONE clears done_o and begins a new W0 the next cycle.
